// File: rtl/add_seq.sv
// add_seq: operand sequencer in front of the combinational Add block.
// Operand pairs are queued in a small FIFO, driven onto add_a/add_b for a
// fixed settle window, and the resulting add_sum is captured into a
// registered, handshaked result port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid, once high, holds its payload stable until that transfer, and
// ready never depends combinationally on valid.
//
// Optional feature: define ADD_SEQ_OVF_EN to add the out_ovf port. It
// carries the signed-overflow flag, captured together with out_sum.
module add_seq #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             busy,
`ifdef ADD_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [NW-1:0]    cnt;
    logic             full, empty, push, pop, capture;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign busy      = (state != S_IDLE) || !empty;
    assign dbg_state = state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus pop/capture strobes. A pop is only taken from the
    // registered FIFO contents, so a push into an empty FIFO pops one edge later.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == NW'(1)) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = S_SETTLE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // Operand registers change only on a pop, keeping Add's inputs stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= '0;
            add_b <= '0;
        end else if (pop) begin
            add_a <= mem_a[rd_ptr];
            add_b <= mem_b[rd_ptr];
        end
    end

    // Settle counter: loaded on pop, counts down while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (pop)               cnt <= NW'(SETTLE);
        else if (state == S_SETTLE) cnt <= cnt - NW'(1);
    end

    // Result register: capture at end of settle, release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_sum   <= add_sum;
            out_valid <= 1'b1;
        end else if (state == S_HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADD_SEQ_OVF_EN
    // Signed overflow: like-signed operands giving a differently-signed sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       out_ovf <= 1'b0;
        else if (capture) out_ovf <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    end
`endif

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: behavioural Add model, table of single operations,
// plus hand-written fill/wrap, backpressure and reset sequences.
module tb_add_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef ADD_SEQ_OVF_EN
    logic         out_ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    // combinational Add model
    assign add_sum = add_a + add_b;

    add_seq #(.WIDTH(W), .DEPTH(4), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .busy(busy),
`ifdef ADD_SEQ_OVF_EN
        .out_ovf(out_ovf),
`endif
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Offer one pair; returns #1 after the accepting edge with in_valid low.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int last;
        int cyc;
        int seen;

        vecs[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vecs[7] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0};

        // reset state
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   out_sum, 32'd0);
        check("rst_add_a",     add_a,   32'd0);
        check("rst_add_b",     add_b,   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
`ifdef ADD_SEQ_OVF_EN
        check("rst_ovf",       {31'd0, out_ovf},   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // table: single ops with out_ready high, latency 3 edges after accept
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].a, vecs[i].b);
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("vec%0d_latency", i), n, 32'd3);
            check($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
`ifdef ADD_SEQ_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].ovf});
`endif
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_clr", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("vec%0d_busy_clr", i), {31'd0, busy}, 32'd0);
        end

        // backpressure: hold a result 10 cycles while another pair queues
        out_ready = 1'b0;
        push(32'd100, 32'd23);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        push(32'd40, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum",   out_sum, 32'd123);
            check("bp_add_a", add_a,   32'd100);
            check("bp_add_b", add_b,   32'd23);
            check("bp_state", {30'd0, dbg_state}, 32'd2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_a", add_a, 32'd40);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_next_lat", n, 32'd2);
        check("bp_next_sum", out_sum, 32'd42);
        @(posedge clk); #1;
        check("bp_idle", {31'd0, busy}, 32'd0);

        // fill and wrap: 5 accepted with out_ready low, then drain 6 in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h0001_0000 * (i + 1), 32'd3 * i + 1);
            exp_q.push_back(32'h0001_0000 * (i + 1) + 32'd3 * i + 1);
        end
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.push_back(32'h0006_0000 + 32'd16);
        out_ready = 1'b1;
        fork
            push(32'h0006_0000, 32'd16);
            begin
                last = 0;
                seen = 0;
                cyc  = 0;
                while (seen < 6 && cyc < 60) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        check($sformatf("fill_sum%0d", seen), out_sum,
                              (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
                        if (seen > 0) check($sformatf("fill_gap%0d", seen), cyc - last, 32'd3);
                        last = cyc;
                        seen++;
                    end
                end
                check("fill_count", seen, 32'd6);
            end
        join
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("fill_idle", {31'd0, busy}, 32'd0);

        // reset during SETTLE with two pairs queued
        out_ready = 1'b0;
        push(32'd9, 32'd9);
        push(32'd8, 32'd8);
        push(32'd7, 32'd7);
        check("mid_state", {30'd0, dbg_state}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_valid", {31'd0, out_valid}, 32'd0);
        check("mid_busy",  {31'd0, busy},      32'd0);
        check("mid_ready", {31'd0, in_ready},  32'd1);
        check("mid_add_a", add_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_ready", {31'd0, in_ready}, 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) n++;
        end
        check("post_no_stale", n, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
